// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: steers PC/IF-ID enables for stalls, branch redirects, and halt.
// Optional performance counters are enabled by defining FETCH_SEQ_PERF_CNT_EN.
module fetch_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        HazardStall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Halt,
    input  logic        Resume,
    output logic        PCSel,
    output logic [31:0] BranchPC,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic [1:0]  State,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t     state;
    state_t     state_next;
    logic [2:0] bubbles;
    logic [2:0] bubbles_next;
    logic       redirect;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= RUN;
            bubbles  <= '0;
            BranchPC <= '0;
        end else begin
            state   <= state_next;
            bubbles <= bubbles_next;
            if (redirect)
                BranchPC <= BranchTarget;
        end
    end

    always_comb begin
        state_next   = state;
        bubbles_next = bubbles;
        redirect     = 1'b0;
        PCSel        = 1'b0;
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;

        case (state)
            RUN, STALL: begin
                if (BranchTaken) begin
                    redirect     = 1'b1;
                    state_next   = FLUSH;
                    bubbles_next = FLUSH_LOAD;
                end else if (Halt) begin
                    state_next = HALT;
                end else if (HazardStall) begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    state_next = STALL;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                // Only the first bubble cycle loads the redirect target into the PC.
                IFID_Flush = 1'b1;
                if (bubbles == FLUSH_LOAD)
                    PCSel = 1'b1;
                else
                    PCWrite = 1'b0;
                if (BranchTaken) begin
                    redirect     = 1'b1;
                    bubbles_next = FLUSH_LOAD;
                end else if (bubbles <= 3'd1) begin
                    state_next   = RUN;
                    bubbles_next = '0;
                end else begin
                    bubbles_next = bubbles - 3'd1;
                end
            end
            HALT: begin
                PCWrite    = 1'b0;
                IFID_Flush = 1'b1;
                if (Resume)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase

        // Reset overrides everything so the front end sees a frozen PC and NOPs.
        if (!Reset_n) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IFID_Flush = 1'b1;
            PCSel      = 1'b0;
            redirect   = 1'b0;
        end
    end

    assign State = state;

`ifdef FETCH_SEQ_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!PCWrite && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            if (redirect && (flush_count != 32'hFFFF_FFFF))
                flush_count <= flush_count + 32'd1;
        end
    end

    assign StallCount = stall_count;
    assign FlushCount = flush_count;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
